// File: rtl/msg_pkg.sv
// Coherence-message types and field layout, shared by the outbound tx queue and the arbiter-side decoder.
package msg_pkg;

    localparam int unsigned MSG_TYPE_W     = 4;
    localparam int unsigned MSG_ID_MAX_W   = 8;
    localparam int unsigned MSG_ADDR_MAX_W = 64;
    localparam int unsigned MSG_MAX_W      = MSG_TYPE_W + 2 * MSG_ID_MAX_W + MSG_ADDR_MAX_W;

    typedef enum logic [MSG_TYPE_W-1:0] {
        RD_REQ  = 4'h0,
        WR_REQ  = 4'h1,
        INV     = 4'h2,
        INV_ACK = 4'h3,
        DATA    = 4'h4,
        EVICT   = 4'h5
    } msg_type_e;

    // Field offsets of {type, src, dst, addr}, MSB first, for a given ID/address width.
    function automatic int unsigned msg_width(input int unsigned id_w, input int unsigned addr_w);
        return MSG_TYPE_W + 2 * id_w + addr_w;
    endfunction

    function automatic int unsigned msg_dst_lsb(input int unsigned addr_w);
        return addr_w;
    endfunction

    function automatic int unsigned msg_src_lsb(input int unsigned id_w, input int unsigned addr_w);
        return id_w + addr_w;
    endfunction

    function automatic int unsigned msg_type_lsb(input int unsigned id_w, input int unsigned addr_w);
        return 2 * id_w + addr_w;
    endfunction

    // Result is left-padded to MSG_MAX_W; callers size-cast it to their msg_width().
    function automatic logic [MSG_MAX_W-1:0] msg_pack(
        input logic [MSG_TYPE_W-1:0]     mtype,
        input logic [MSG_ID_MAX_W-1:0]   src,
        input logic [MSG_ID_MAX_W-1:0]   dst,
        input logic [MSG_ADDR_MAX_W-1:0] addr,
        input int unsigned               id_w,
        input int unsigned               addr_w
    );
        logic [MSG_MAX_W-1:0] word;
        word = MSG_MAX_W'(addr);
        word = word | (MSG_MAX_W'(dst)   << msg_dst_lsb(addr_w));
        word = word | (MSG_MAX_W'(src)   << msg_src_lsb(id_w, addr_w));
        word = word | (MSG_MAX_W'(mtype) << msg_type_lsb(id_w, addr_w));
        return word;
    endfunction

endpackage

// File: rtl/msg_fifo_core.sv
// Generic synchronous FIFO; full/empty are decoded from the registered occupancy count.
module msg_fifo_core #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/msg_tx_queue.sv
// Per-cache outbound coherence-message queue feeding the arbiter request/grant slice.
// Optional MSG_TX_STATS_EN adds sent_cnt and hwm (occupancy high-water mark) outputs.
module msg_tx_queue
    import msg_pkg::*;
#(
    parameter  int unsigned CACHE_NUM = 2,
    parameter  int unsigned CACHE_ID  = 0,
    parameter  int unsigned ADDR_W    = 32,
    parameter  int unsigned DEPTH     = 4,
    localparam int unsigned ID_W      = $clog2(CACHE_NUM),
    localparam int unsigned MSG_W     = MSG_TYPE_W + 2 * ID_W + ADDR_W,
    localparam int unsigned CW        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MSG_TYPE_W-1:0] in_type,
    input  logic [ID_W-1:0]       in_dst,
    input  logic [ADDR_W-1:0]     in_addr,
    output logic                  msg_req,
    input  logic                  msg_gnt,
    output logic [MSG_W-1:0]      msg,
    output logic [CW-1:0]         count,
    output logic                  err_spur_gnt
`ifdef MSG_TX_STATS_EN
    ,
    output logic [31:0]           sent_cnt,
    output logic [CW-1:0]         hwm
`endif
);

    logic [MSG_W-1:0] wr_entry;
    logic             fifo_full, fifo_empty;
    logic             pop_fire;
    logic             err_q, err_d;

    assign wr_entry = MSG_W'(msg_pack(in_type,
                                      MSG_ID_MAX_W'(CACHE_ID),
                                      MSG_ID_MAX_W'(in_dst),
                                      MSG_ADDR_MAX_W'(in_addr),
                                      ID_W, ADDR_W));

    msg_fifo_core #(
        .WIDTH (MSG_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_valid),
        .pop_i   (msg_gnt),
        .wdata_i (wr_entry),
        .rdata_o (msg),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_ready = !fifo_full;
    assign msg_req  = !fifo_empty;
    assign pop_fire = msg_gnt && !fifo_empty;

    always_comb begin
        err_d = err_q;
        if (msg_gnt && fifo_empty) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err_spur_gnt = err_q;

`ifdef MSG_TX_STATS_EN
    logic [31:0]   sent_q, sent_d;
    logic [CW-1:0] hwm_q, hwm_d;

    always_comb begin
        sent_d = sent_q + 32'(pop_fire);
        hwm_d  = hwm_q;
        if (count > hwm_q) hwm_d = count;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sent_q <= '0;
            hwm_q  <= '0;
        end else begin
            sent_q <= sent_d;
            hwm_q  <= hwm_d;
        end
    end

    assign sent_cnt = sent_q;
    assign hwm      = hwm_q;
`else
    logic unused_pop_fire;
    assign unused_pop_fire = pop_fire;
`endif

endmodule
